// File: rtl/core_pkg.sv
// Shared core definitions: datapath widths, base opcodes and fetch FSM states.
package core_pkg;

  localparam int unsigned XLEN = 64;
  localparam int unsigned ILEN = 32;

  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    HALT
  } fetch_state_t;

  function automatic logic [6:0] opcode_of(input logic [ILEN-1:0] instr);
    return instr[6:0];
  endfunction

endpackage

// File: rtl/fetch_predecode.sv
// Combinational pre-decode of a fetched instruction pair; flags branches per slot.
module fetch_predecode
  import core_pkg::*;
#(
  parameter logic [6:0] BR_OPCODE = OPC_BRANCH
) (
  input  logic [ILEN-1:0] instr1_i,
  input  logic [ILEN-1:0] instr2_i,
  output logic            br1_o,
  output logic            br2_o
);

  always_comb begin
    br1_o = (opcode_of(instr1_i) == BR_OPCODE);
    br2_o = (opcode_of(instr2_i) == BR_OPCODE);
  end

endmodule

// File: rtl/fetch_unit_2way.sv
// Dual-issue fetch stage: owns the PC, drives the instruction memory pair and
// fills the IF/ID register, limiting each bundle to one branch in slot 1.
module fetch_unit_2way
  import core_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC  = 64'h0,
  parameter logic [XLEN-1:0] END_ADDR  = 64'hAC,
  parameter logic [6:0]      BR_OPCODE = 7'b1100011
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            stall,
  input  logic            branch_en,
  input  logic [XLEN-1:0] branch_pc,
  output logic [XLEN-1:0] imem_pc,
  output logic [XLEN-1:0] imem_pc4,
  input  logic [ILEN-1:0] imem_instr1,
  input  logic [ILEN-1:0] imem_instr2,
  output logic [ILEN-1:0] id_instr1,
  output logic [ILEN-1:0] id_instr2,
  output logic [XLEN-1:0] id_pc1,
  output logic [XLEN-1:0] id_pc2,
  output logic            id_valid1,
  output logic            id_valid2,
  output logic            halted
);

  fetch_state_t    state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [ILEN-1:0] id_instr1_q, id_instr1_d, id_instr2_q, id_instr2_d;
  logic [XLEN-1:0] id_pc1_q, id_pc1_d, id_pc2_q, id_pc2_d;
  logic            id_valid1_q, id_valid1_d, id_valid2_q, id_valid2_d;

  logic [XLEN-1:0] pc_plus4;
  logic [XLEN-1:0] pc_plus8;
  logic [XLEN-1:0] redirect_pc;
  logic            slot1_br;
  logic            unused_slot2_br;
  logic            unused_branch_lsb;

  assign pc_plus4          = pc_q + 64'd4;
  assign pc_plus8          = pc_q + 64'd8;
  // Redirect targets are forced word-aligned.
  assign redirect_pc       = {branch_pc[XLEN-1:2], 2'b00};
  assign unused_branch_lsb = ^branch_pc[1:0];

  fetch_predecode #(
    .BR_OPCODE (BR_OPCODE)
  ) u_predecode (
    .instr1_i (imem_instr1),
    .instr2_i (imem_instr2),
    .br1_o    (slot1_br),
    .br2_o    (unused_slot2_br)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      pc_q        <= RESET_PC;
      id_instr1_q <= '0;
      id_instr2_q <= '0;
      id_pc1_q    <= '0;
      id_pc2_q    <= '0;
      id_valid1_q <= 1'b0;
      id_valid2_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      id_instr1_q <= id_instr1_d;
      id_instr2_q <= id_instr2_d;
      id_pc1_q    <= id_pc1_d;
      id_pc2_q    <= id_pc2_d;
      id_valid1_q <= id_valid1_d;
      id_valid2_q <= id_valid2_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: state_d = RUN;
      RUN: begin
        if (branch_en) begin
          state_d = RUN;
        end else if (stall) begin
          state_d = RUN;
        end else if (pc_q >= END_ADDR) begin
          state_d = HALT;
        end
      end
      HALT: begin
        if (branch_en) begin
          state_d = RUN;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // PC and IF/ID register next values; anything not written holds.
  always_comb begin
    pc_d        = pc_q;
    id_instr1_d = id_instr1_q;
    id_instr2_d = id_instr2_q;
    id_pc1_d    = id_pc1_q;
    id_pc2_d    = id_pc2_q;
    id_valid1_d = id_valid1_q;
    id_valid2_d = id_valid2_q;
    unique case (state_q)
      IDLE: begin
        id_valid1_d = 1'b0;
        id_valid2_d = 1'b0;
      end
      RUN: begin
        if (branch_en) begin
          pc_d        = redirect_pc;
          id_valid1_d = 1'b0;
          id_valid2_d = 1'b0;
        end else if (stall) begin
          pc_d = pc_q;
        end else if (pc_q > END_ADDR) begin
          id_valid1_d = 1'b0;
          id_valid2_d = 1'b0;
        end else if (pc_q == END_ADDR || slot1_br) begin
          // Single issue: last instruction, or a branch that must sit alone.
          id_instr1_d = imem_instr1;
          id_pc1_d    = pc_q;
          id_valid1_d = 1'b1;
          id_valid2_d = 1'b0;
          if (pc_q != END_ADDR) begin
            pc_d = pc_plus4;
          end
        end else begin
          id_instr1_d = imem_instr1;
          id_pc1_d    = pc_q;
          id_instr2_d = imem_instr2;
          id_pc2_d    = pc_plus4;
          id_valid1_d = 1'b1;
          id_valid2_d = 1'b1;
          pc_d        = pc_plus8;
        end
      end
      HALT: begin
        id_valid1_d = 1'b0;
        id_valid2_d = 1'b0;
        if (branch_en) begin
          pc_d = redirect_pc;
        end
      end
      default: begin
        id_valid1_d = 1'b0;
        id_valid2_d = 1'b0;
      end
    endcase
  end

  // Outputs.
  always_comb begin
    imem_pc  = pc_q;
    imem_pc4 = pc_plus4;
    halted   = (state_q == HALT);
  end

  assign id_instr1 = id_instr1_q;
  assign id_instr2 = id_instr2_q;
  assign id_pc1    = id_pc1_q;
  assign id_pc2    = id_pc2_q;
  assign id_valid1 = id_valid1_q;
  assign id_valid2 = id_valid2_q;

endmodule

// File: doc/fetch_unit_2way.md
Name: fetch_unit_2way

Overview:
- Dual-issue instruction fetch stage for the 2-way superscalar core.
- Drives the byte-address pair (PC, PC+4) into the combinational instruction memory and captures the returned instr1/instr2 into the IF/ID pipeline register.
- Owns the program counter: sequential advance, branch redirect with flush, stall hold, one-branch-per-bundle pre-decode, and end-of-program halt.

Parameters:
- RESET_PC, 64'h0, PC loaded on reset.
- END_ADDR, 64'hAC, byte address of the last valid instruction; fetch halts after issuing it.
- BR_OPCODE, 7'b1100011, opcode treated as a branch by slot-1 pre-decode.

Ports:
- clk  in  1  core clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- stall  in  1  hazard-unit hold request.
- branch_en  in  1  redirect request from EX.
- branch_pc  in  64  redirect target (byte address).
- imem_pc  out  64  slot-1 fetch address = pc_q (combinational from the register).
- imem_pc4  out  64  slot-2 fetch address = pc_q + 4.
- imem_instr1  in  32  instruction at imem_pc, valid in the same cycle.
- imem_instr2  in  32  instruction at imem_pc4, valid in the same cycle.
- id_instr1, id_instr2  out  32 each  IF/ID instruction registers.
- id_pc1, id_pc2  out  64 each  IF/ID PC registers.
- id_valid1, id_valid2  out  1 each  slot valid bits.
- halted  out  1  high while in HALT.

Behaviour:
- Reset (async, rst_n=0):
  - pc_q=RESET_PC, state=IDLE.
  - All id_* registers = 0, id_valid1 = id_valid2 = 0, halted = 0.
- FSM states: IDLE, RUN, HALT.
  - IDLE: one bubble cycle after reset release. Valids stay 0, pc_q holds. Next state is RUN unconditionally.
  - RUN, priority order on each edge:
    1. branch_en=1: pc_q <= {branch_pc[63:2],2'b00} (misaligned low bits are cleared); id_valid1 = id_valid2 = 0 (flush). Redirect overrides stall.
    2. stall=1: pc_q and all id_* registers hold their values.
    3. pc_q > END_ADDR: valids <= 0, next state HALT.
    4. pc_q == END_ADDR: issue slot 1 only (id_valid1=1, id_valid2=0), next state HALT.
    5. imem_instr1[6:0]==BR_OPCODE: issue slot 1 only; pc_q <= pc_q+4, so instr2 is refetched as slot 1 next cycle.
    6. Otherwise: issue both slots; id_pc1=pc_q, id_pc2=pc_q+4; pc_q <= pc_q+8.
  - HALT: valids 0, pc_q holds, halted=1.
    - branch_en=1 performs the redirect and returns to RUN. This covers an older in-flight branch resolving late.
    - stall is ignored in HALT.
- Latency: instruction presented at imem_pc in cycle N appears on id_* in cycle N+1.
- Arithmetic is 64-bit unsigned, wrapping modulo 2^64; no overflow detection.
- When a slot is invalid, its id_instr/id_pc registers hold stale data. Consumers must gate on the valid bits.
- Reset asserted mid-operation takes effect immediately regardless of stall or branch_en.

Decomposition:
- Shared package (core_pkg):
  - XLEN=64, ILEN=32.
  - Opcode constants: OPC_BRANCH, OPC_LOAD, OPC_STORE, OPC_OP, OPC_OP_IMM.
  - fetch_state_t enum {IDLE, RUN, HALT}.
- One natural sub-module: fetch_predecode. It is combinational and takes instr1/instr2. It outputs a slot-1 branch flag and is reusable later for branch prediction.
- Everything else (PC register, FSM, IF/ID register) lives in fetch_unit_2way.

Test Plan:
- Reset then release, memory holding ADD at 0x0 and ADDI at 0x4: cycle 1 all valids 0 (IDLE); cycle 2 id_pc1=0, id_instr1=32'h015A04B3, id_pc2=4, id_instr2=32'h00148493, both valids 1; imem_pc=8.
- BEQ (32'h02740463) at 0x2C with pc_q=0x2C: only id_valid1=1, id_instr1=32'h02740463; next imem_pc=0x30.
- stall=1 for 3 cycles at pc_q=0x10: imem_pc stays 0x10 and id_* stay unchanged. After release, the 0x10/0x14 pair issues.
- branch_en=1 with branch_pc=0x56 and stall=1 in the same cycle: valids 0 next cycle, pc_q=0x54; the following cycle issues ORI 32'h014AEA13 at id_pc1=0x54.
- Run to END_ADDR=0xAC: last bundle is id_pc1=0xAC with id_valid2=0; halted=1 thereafter, with pc and valids frozen. Then branch_en=1 with branch_pc=0x78: state returns to RUN and 0x78/0x7C issue.
- Assert rst_n=0 asynchronously mid-RUN (pc_q=0x40): pc_q=0, valids=0 without waiting for a clk edge; after release, IDLE bubble then fetch resumes from 0x0.
